// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared op codes, FSM states and defaults for the HI/LO mul/div block
package hilo_pkg;

  localparam int HILO_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_RUN,
    ST_FIXUP,
    ST_WRITE
  } state_t;

  // Bit 1 of the op code selects divide, bit 0 clear means a signed op.
  function automatic logic op_is_div(input logic [1:0] code);
    return code[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] code);
    return ~code[0];
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - one shift-add (multiply) or restoring shift-subtract (divide) step
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  // Multiply: acc = {partial product, remaining multiplier bits}, add on LSB then shift right.
  // Divide:   acc = {partial remainder, remaining dividend/quotient bits}, shift left and
  //           keep the subtraction only when it does not borrow.
  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] trial;

  // Single combinational iteration selected by mode.
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    acc_next = {add_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (trial[WIDTH]) begin
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - multi-cycle HI/LO multiply/divide sequencer with pipeline interlock
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             mfhi_req,
  input  logic             mflo_req,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         code;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   b_raw;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] fix_val;
  logic               res_neg;
  logic               rem_neg;
  logic               dbz;
  logic               write_r;
  logic               dbz_r;

  logic               is_div;
  logic               is_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  assign is_div    = op_is_div(code);
  assign is_signed = op_is_signed(code);
  assign a_mag     = (is_signed && a_raw[WIDTH-1]) ? -a_raw : a_raw;
  assign b_mag     = (is_signed && b_raw[WIDTH-1]) ? -b_raw : b_raw;

  assign busy  = (state != ST_IDLE);
  assign stall = busy & (mfhi_req | mflo_req | mthi_we | mtlo_we | op_valid);

  // A flush arriving in the WRITE cycle cancels the commit, so it also hides the pulse.
  assign done        = write_r & ~flush;
  assign div_by_zero = dbz_r & ~flush;

  muldiv_iter_core #(
    .WIDTH (WIDTH)
  ) u_iter (
    .acc      (acc),
    .opnd     (opnd),
    .is_div   (is_div),
    .acc_next (acc_step)
  );

  // Sign correction of the unsigned result; divide by zero bypasses it with the fixed pattern.
  always_comb begin
    fix_val = acc;
    if (dbz) begin
      fix_val = {a_raw, {WIDTH{1'b1}}};
    end else if (is_div) begin
      fix_val[WIDTH-1:0]       = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fix_val[2*WIDTH-1:WIDTH] = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end else if (res_neg) begin
      fix_val = -acc;
    end
  end

  // Sequencer: issue, operand prep, WIDTH iterations, sign fixup, HI/LO commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      code    <= '0;
      a_raw   <= '0;
      b_raw   <= '0;
      opnd    <= '0;
      acc     <= '0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      dbz     <= 1'b0;
      write_r <= 1'b0;
      dbz_r   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      write_r <= 1'b0;
      dbz_r   <= 1'b0;
      if (state != ST_IDLE && flush) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (mthi_we) hi <= mt_data;
            if (mtlo_we) lo <= mt_data;
            if (op_valid && !flush) begin
              code  <= op_code;
              a_raw <= op_a;
              b_raw <= op_b;
              state <= ST_PREP;
            end
          end
          ST_PREP: begin
            res_neg <= is_signed & (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
            rem_neg <= is_signed & a_raw[WIDTH-1];
            dbz     <= is_div && (b_raw == '0);
            if (is_div) begin
              acc  <= {{WIDTH{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {{WIDTH{1'b0}}, b_mag};
              opnd <= a_mag;
            end
            cnt   <= '0;
            state <= ST_RUN;
          end
          ST_RUN: begin
            acc <= acc_step;
            if (cnt == LAST_ITER) begin
              cnt   <= '0;
              state <= ST_FIXUP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_FIXUP: begin
            acc     <= fix_val;
            write_r <= 1'b1;
            dbz_r   <= dbz;
            state   <= ST_WRITE;
          end
          ST_WRITE: begin
            hi    <= acc[2*WIDTH-1:WIDTH];
            lo    <= acc[WIDTH-1:0];
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb/tb_hilo_muldiv_ctrl.sv - self-checking bench for hilo_muldiv_ctrl
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [1:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] mt_data;
  logic        mfhi_req;
  logic        mflo_req;
  logic        flush;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  typedef struct {
    logic [1:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        ez;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  hilo_muldiv_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .op_a        (op_a),
    .op_b        (op_b),
    .mthi_we     (mthi_we),
    .mtlo_we     (mtlo_we),
    .mt_data     (mt_data),
    .mfhi_req    (mfhi_req),
    .mflo_req    (mflo_req),
    .flush       (flush),
    .busy        (busy),
    .stall       (stall),
    .hi          (hi),
    .lo          (lo),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result from plain 64-bit arithmetic.
  function automatic void model(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mh, output logic [31:0] ml, output logic mz);
    longint      p;
    logic [63:0] u;
    int          q;
    int          r;
    mz = 1'b0;
    mh = '0;
    ml = '0;
    case (c)
      OP_MULT: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        mh = p[63:32];
        ml = p[31:0];
      end
      OP_MULTU: begin
        u  = {32'b0, a} * {32'b0, b};
        mh = u[63:32];
        ml = u[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          mh = a;
          ml = 32'hFFFF_FFFF;
          mz = 1'b1;
        end else if (c == OP_DIVU) begin
          ml = a / b;
          mh = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          ml = 32'h8000_0000;
          mh = 32'h0;
        end else begin
          q  = $signed(a) / $signed(b);
          r  = $signed(a) % $signed(b);
          ml = q;
          mh = r;
        end
      end
    endcase
  endfunction

  // Issue one op, time it to done, then check the committed HI/LO.
  task automatic run_op(input string tag, input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic ez);
    int n;
    @(negedge clk);
    op_valid = 1'b1; op_code = c; op_a = a; op_b = b;
    @(negedge clk);
    op_valid = 1'b0; op_code = 2'($urandom); op_a = $urandom; op_b = $urandom;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " done latency"}, 32'(n), 32'd34);
    chk({tag, " div_by_zero"}, {31'b0, div_by_zero}, {31'b0, ez});
    @(negedge clk);
    chk({tag, " hi"}, hi, ehi);
    chk({tag, " lo"}, lo, elo);
    chk({tag, " busy after"}, {31'b0, busy}, 32'd0);
    exp_hi = ehi;
    exp_lo = elo;
  endtask

  initial begin
    logic [1:0]  rc;
    logic [31:0] ra, rb, mh, ml;
    logic        mz;
    int          cnt;

    vecs[0] = '{OP_DIVU,  32'd7,          32'd2,          32'h0000_0001, 32'h0000_0003, 1'b0};
    vecs[1] = '{OP_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[2] = '{OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[3] = '{OP_MULT,  32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[4] = '{OP_MULTU, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    vecs[5] = '{OP_DIVU,  32'h0000_1234,  32'd0,          32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    vecs[6] = '{OP_DIV,   32'd9,          32'hFFFF_FFFC,  32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    vecs[7] = '{OP_MULT,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0};

    rst = 1'b1; op_valid = 1'b0; op_code = '0; op_a = '0; op_b = '0;
    mthi_we = 1'b0; mtlo_we = 1'b0; mt_data = '0; mfhi_req = 1'b0; mflo_req = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset dbz", {31'b0, div_by_zero}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);

    // Interlock: mfhi/mflo requested right after issue stalls until result is visible.
    @(negedge clk);
    op_valid = 1'b1; op_code = OP_DIVU; op_a = 32'd7; op_b = 32'd2;
    @(negedge clk);
    op_valid = 1'b0; mfhi_req = 1'b1; mflo_req = 1'b1;
    cnt = 0;
    #1;
    while (stall && cnt < 60) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    chk("mf stall cycles", 32'(cnt), 32'd35);
    chk("mfhi read", hi, 32'd1);
    chk("mflo read", lo, 32'd3);
    mfhi_req = 1'b0; mflo_req = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].ez);
    end

    for (int i = 0; i < 20; i++) begin
      rc = 2'($urandom);
      ra = ($urandom_range(3) == 0) ? 32'($urandom_range(1000)) : $urandom;
      rb = ($urandom_range(7) == 0) ? 32'd0 : (($urandom_range(3) == 0) ? 32'($urandom_range(20)) : $urandom);
      model(rc, ra, rb, mh, ml, mz);
      run_op($sformatf("rnd%0d op%0d", i, rc), rc, ra, rb, mh, ml, mz);
    end

    // Same-cycle mthi and issue: mthi lands first, the op result overwrites it.
    @(negedge clk);
    op_valid = 1'b1; op_code = OP_DIVU; op_a = 32'd50; op_b = 32'd3;
    mthi_we = 1'b1; mt_data = 32'h0000_1357;
    @(negedge clk);
    op_valid = 1'b0; mthi_we = 1'b0;
    chk("mthi with issue", hi, 32'h0000_1357);
    cnt = 0;
    while (!done && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    chk("op overwrites mthi hi", hi, 32'd2);
    chk("op overwrites mthi lo", lo, 32'd16);
    exp_hi = 32'd2; exp_lo = 32'd16;

    // Flush during RUN cycle 10: no commit, no done.
    @(negedge clk);
    mthi_we = 1'b1; mt_data = 32'hAAAA_0000;
    @(negedge clk);
    mthi_we = 1'b0;
    chk("mthi idle", hi, 32'hAAAA_0000);
    op_valid = 1'b1; op_code = OP_DIV; op_a = 32'd9; op_b = 32'd4;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (11) @(negedge clk);
    chk("busy before flush", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("busy after flush", {31'b0, busy}, 32'd0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) cnt++;
      @(negedge clk);
    end
    chk("no done after flush", 32'(cnt), 32'd0);
    chk("hi after flush", hi, 32'hAAAA_0000);
    chk("lo after flush", lo, exp_lo);

    // Flush alongside issue in IDLE is ignored.
    op_valid = 1'b1; op_code = OP_MULTU; op_a = 32'd3; op_b = 32'd3; flush = 1'b1;
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0;
    chk("flush blocks issue", {31'b0, busy}, 32'd0);

    // Reset mid-RUN clears everything.
    op_valid = 1'b1; op_code = OP_MULT; op_a = 32'd3; op_b = 32'd5;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst mid busy", {31'b0, busy}, 32'd0);
    chk("rst mid hi", hi, 32'd0);
    chk("rst mid lo", lo, 32'd0);

    // Requests held while busy stall and are not taken.
    op_valid = 1'b1; op_code = OP_DIVU; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    op_op_hold: begin
      op_code = OP_MULTU; op_a = 32'd9; op_b = 32'd9;
      mthi_we = 1'b1; mt_data = 32'h5555_5555;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
        #1;
        if (stall) cnt++;
        @(negedge clk);
      end
      op_valid = 1'b0; mthi_we = 1'b0;
    end
    chk("held stall cycles", 32'(cnt), 32'd10);
    chk("held mthi not taken", hi, 32'd0);
    cnt = 0;
    while (!done && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    chk("held done latency", 32'(cnt), 32'd24);
    @(negedge clk);
    chk("held op hi", hi, 32'd2);
    chk("held op lo", lo, 32'd14);
    chk("held op idle", {31'b0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Multi-cycle sequencer for the HI/LO multiply/divide resource of the pipelined core.
- Accepts mult/multu/div/divu from the EX stage and runs an iterative shift-add or shift-subtract over WIDTH cycles.
- Owns and commits the HI and LO registers.
- Generates the interlock that stalls mfhi/mflo, mthi/mtlo and back-to-back issue until the result is architecturally visible.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  issue strobe from EX, one cycle.
- op_code  in  2  00 mult, 01 multu, 10 div, 11 divu.
- op_a  in  WIDTH  rs value (dividend/multiplicand).
- op_b  in  WIDTH  rt value (divisor/multiplier).
- mthi_we  in  1  mthi request.
- mtlo_we  in  1  mtlo request.
- mt_data  in  WIDTH  data for mthi/mtlo.
- mfhi_req  in  1  mfhi in decode.
- mflo_req  in  1  mflo in decode.
- flush  in  1  kill in-flight op (branch/exception).
- busy  out  1  state != IDLE.
- stall  out  1  combinational pipeline hold.
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.
- done  out  1  high for the single WRITE cycle.
- div_by_zero  out  1  high with done when a div/divu had op_b == 0.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0, counter = 0.
- Reset mid-operation aborts the op; hi/lo return to 0.
- FSM states: IDLE -> PREP -> RUN -> FIXUP -> WRITE -> IDLE.
- IDLE: op_valid latches op_code, op_a, op_b; next state PREP.
- PREP, signed ops: capture operand magnitudes; record result sign (a XOR b) and remainder sign (sign of a).
- PREP, unsigned ops: pass operands through unchanged.
- RUN: exactly WIDTH cycles; counter 0..WIDTH-1.
  - Multiply: one shift-add per cycle into a 2*WIDTH accumulator.
  - Divide: one restoring shift-subtract per cycle.
- FIXUP, multiply: negate the 2*WIDTH product if result sign = 1.
- FIXUP, divide: negate quotient if result sign = 1; negate remainder if remainder sign = 1.
- WRITE: done = 1; hi/lo load on the clock edge that ends WRITE.
  - Multiply: hi = product[2W-1:W], lo = product[W-1:0].
  - Divide: lo = quotient, hi = remainder.
- Latency: issue edge to hi/lo visible is WIDTH + 3 cycles (35 at default). Next op may issue the cycle after WRITE.
- Divide by zero: skip FIXUP arithmetic; commit lo = all ones and hi = op_a (raw, unmodified). div_by_zero = 1 during WRITE.
- Signed overflow (0x80000000 / -1): lo = 0x80000000, hi = 0 (two's-complement wrap). No flag.
- stall = busy & (mfhi_req | mflo_req | mthi_we | mtlo_we | op_valid).
  - The requester holds its request; this block ignores it until IDLE.
- No bypass: mfhi/mflo in the WRITE cycle still stalls and reads the new value the following cycle.
- mthi/mtlo in IDLE: write hi/lo on the next edge.
- Same-cycle mthi_we and op_valid in IDLE: mt write applies and the op starts; the op result later overwrites.
- flush in any non-IDLE state: state -> IDLE next edge; hi/lo unchanged; no done pulse. Flush has priority over WRITE commit.
- flush with op_valid in IDLE: op ignored.
- op_code is don't-care while op_valid = 0. Operand inputs are sampled only at issue.

Decomposition:
- Shared package hilo_pkg: op-code constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), FSM state enum, default WIDTH.
- Sub-module muldiv_iter_core:
  - Purely combinational single-iteration step, taking accumulator, operand and mode and returning the next accumulator.
  - hilo_muldiv_ctrl owns the FSM, counter, sign bookkeeping, HI/LO registers and stall.

Test Plan:
- divu 7 / 2, then mfhi/mflo issued the next cycle -> stall high for 35 cycles; lo = 0x00000003, hi = 0x00000001; mfhi reads 1, mflo reads 3.
- div 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- mult 0xFFFFFFFF * 2 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFFE. multu same operands -> hi = 0x00000001, lo = 0xFFFFFFFE.
- divu 0x1234 / 0 -> div_by_zero = 1 with done; lo = 0xFFFFFFFF, hi = 0x00001234.
- mthi 0xAAAA0000 in IDLE, then div 9/4 with flush at RUN cycle 10 -> busy drops next cycle; hi stays 0xAAAA0000, lo unchanged; no done pulse.
- rst asserted mid-RUN -> next edge state IDLE, hi = lo = 0, busy = 0; op_valid with mthi_we during busy -> stall = 1, neither takes effect until IDLE.
